// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU; registered operands/results, 3+ cycles per op.
// Optional saturating grant counters under ALU_SHARE_ARB_STATS_EN (ports tied to 0 when undefined).
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_c,
   output logic             rsp0_eq,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_c,
   output logic             rsp1_eq,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_eq,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OPW-1:0]   op;
   } opnd_t;

   state_t           state, state_nxt;
   opnd_t            opnd;
   logic [WIDTH-1:0] res_c;
   logic             res_eq;
   logic             owner;
   logic             last_grant;
   logic             win0, win1;
   logic             hs0, hs1;
   logic             rsp_hs;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (req0_valid && req1_valid) begin
         win0 = last_grant;
         win1 = ~last_grant;
      end else begin
         win0 = req0_valid;
         win1 = req1_valid;
      end
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp_hs     = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = win0;
            req1_ready = win1;
            if (win0 || win1)
               state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
            rsp_hs     = owner ? rsp1_ready : rsp0_ready;
            if (rsp_hs)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign hs0 = req0_ready;
   assign hs1 = req1_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         opnd       <= '0;
         res_c      <= '0;
         res_eq     <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (hs0 || hs1) begin
            opnd       <= hs1 ? opnd_t'{req1_a, req1_b, req1_op} : opnd_t'{req0_a, req0_b, req0_op};
            owner      <= hs1;
            last_grant <= hs1;
         end
         if (state == EXEC) begin
            res_c  <= alu_c;
            res_eq <= alu_eq;
         end
      end
   end

   // ALU sees only registered operands, isolating it from requester timing.
   assign alu_a  = opnd.a;
   assign alu_b  = opnd.b;
   assign alu_op = opnd.op;

   assign rsp0_c  = res_c;
   assign rsp0_eq = res_eq;
   assign rsp1_c  = res_c;
   assign rsp1_eq = res_eq;

`ifdef ALU_SHARE_ARB_STATS_EN
   logic [15:0] cnt0, cnt1;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (hs0 && cnt0 != 16'hFFFF)
            cnt0 <= cnt0 + 16'd1;
         if (hs1 && cnt1 != 16'hFFFF)
            cnt1 <= cnt1 + 16'd1;
      end
   end

   assign grant_cnt0 = cnt0;
   assign grant_cnt1 = cnt1;
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU model.
module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_eq;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_eq;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_c, rsp1_c;
   logic [2:0]  req0_op, req1_op, alu_op;
   logic [31:0] alu_a, alu_b, alu_c;
   logic        alu_eq;
   logic [15:0] grant_cnt0, grant_cnt1;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   // ALU model: op 000 add, 001 subtract, anything else xor.
   always_comb begin
      case (alu_op)
         3'b000:  alu_c = alu_a + alu_b;
         3'b001:  alu_c = alu_a - alu_b;
         default: alu_c = alu_a ^ alu_b;
      endcase
      alu_eq = (alu_a == alu_b);
   end

   alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_eq(rsp0_eq),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_eq(rsp1_eq),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_eq(alu_eq),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge in IDLE with requests set up and rsp readies high; leaves at the IDLE negedge after.
   task automatic op_cycle(input logic who, input logic [2:0] op, input logic [31:0] c, input logic eq);
      #1;
      chk("grant0", {31'd0, req0_ready}, {31'd0, ~who});
      chk("grant1", {31'd0, req1_ready}, {31'd0, who});
      @(negedge clk);
      chk("exec_no_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("exec_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("exec_op", {29'd0, alu_op}, {29'd0, op});
      @(negedge clk);
      chk("rsp_valids", {30'd0, rsp1_valid, rsp0_valid}, who ? 32'd2 : 32'd1);
      chk("rsp_c", who ? rsp1_c : rsp0_c, c);
      chk("rsp_eq", {31'd0, who ? rsp1_eq : rsp0_eq}, {31'd0, eq});
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("rst_rsp_c", rsp0_c, 32'd0);
      chk("rst_cnt", {grant_cnt0, grant_cnt1}, 32'd0);
      reset = 1'b0;

      // Single operation from requester 0, operands changed right after the handshake.
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h00010001; req0_b = 32'd60; req0_op = 3'b000;
      #1;
      chk("single_rdy0", {31'd0, req0_ready}, 32'd1);
      chk("single_rdy1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      req0_valid = 0; req0_a = 32'hDEADBEEF; req0_b = 32'h12345678;
      #1;
      chk("single_exec_rdy", {31'd0, req0_ready}, 32'd0);
      chk("iso_alu_a", alu_a, 32'h00010001);
      chk("iso_alu_b", alu_b, 32'd60);
      @(negedge clk);
      chk("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("single_rsp0_c", rsp0_c, 32'h0001003D);
      chk("single_rsp0_eq", {31'd0, rsp0_eq}, 32'd0);
      rsp0_ready = 1;
      @(negedge clk);
      chk("single_done", {31'd0, rsp0_valid}, 32'd0);
      rsp0_ready = 0;

      // Simultaneous requests after reset: 0 first, then strict alternation.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0_a = 5; req0_b = 5; req0_op = 0; req0_valid = 1;
      req1_a = 7; req1_b = 1; req1_op = 0; req1_valid = 1;
      rsp0_ready = 1; rsp1_ready = 1;
      op_cycle(1'b0, 3'b000, 32'd10, 1'b1);
      op_cycle(1'b1, 3'b000, 32'd8, 1'b0);
      op_cycle(1'b0, 3'b000, 32'd10, 1'b1);
      op_cycle(1'b1, 3'b000, 32'd8, 1'b0);

      // Response backpressure on requester 0 while requester 1 waits.
      rsp0_ready = 0; rsp1_ready = 0;
      #1;
      chk("bp_rdy0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
         chk("bp_rsp0_c", rsp0_c, 32'd10);
         chk("bp_rdy1", {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp0_ready = 1;
      #1;
      chk("bp_rdy1_same_cycle", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      rsp0_ready = 0;
      #1;
      chk("bp_rsp0_dropped", {31'd0, rsp0_valid}, 32'd0);
      chk("bp_rdy1_after", {31'd0, req1_ready}, 32'd1);
      rsp0_ready = 1; rsp1_ready = 1;
      op_cycle(1'b1, 3'b000, 32'd8, 1'b0);

      // Reset during EXEC right after a requester 0 grant.
      req1_valid = 0;
      #1;
      chk("rexec_rdy0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      reset = 1; req0_valid = 0;
      @(negedge clk);
      reset = 0;
      #1;
      chk("rexec_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      chk("rexec_alu_a", alu_a, 32'd0);
      chk("rexec_cnt", {grant_cnt0, grant_cnt1}, 32'd0);
      @(negedge clk);
      chk("rexec_no_rsp2", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      req0_valid = 1; req1_valid = 1;
      op_cycle(1'b0, 3'b000, 32'd10, 1'b1);
      op_cycle(1'b1, 3'b000, 32'd8, 1'b0);
      op_cycle(1'b0, 3'b000, 32'd10, 1'b1);

      // Opcode pass-through on requester 1, then one more requester 0 op.
      req0_valid = 0;
      req1_a = 32'hF0F0F0F0; req1_b = 32'h0F0F0F0F; req1_op = 3'b101;
      op_cycle(1'b1, 3'b101, 32'hFFFFFFFF, 1'b0);
      req1_valid = 0; req0_valid = 1;
      req0_a = 32'd100; req0_b = 32'd58; req0_op = 3'b001;
      op_cycle(1'b0, 3'b001, 32'd42, 1'b0);
      req0_valid = 0;

`ifdef ALU_SHARE_ARB_STATS_EN
      chk("stats_cnt0", {16'd0, grant_cnt0}, 32'd3);
      chk("stats_cnt1", {16'd0, grant_cnt1}, 32'd2);
`else
      chk("stats_cnt0_off", {16'd0, grant_cnt0}, 32'd0);
      chk("stats_cnt1_off", {16'd0, grant_cnt1}, 32'd0);
`endif
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("stats_cleared", {grant_cnt0, grant_cnt1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
